// File: rtl/join3_sync_pkg.sv
// Shared types and default configuration for the join3_sync handshake join controller.
package join3_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    ACK  = 2'b10,
    RTZ  = 2'b11
  } join3_state_e;

  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer with asynchronous active-low clear.
module sync_ff #(
  parameter int unsigned N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  // Fewer than two stages gives no metastability protection, so clamp.
  localparam int unsigned STAGES = (N < 2) ? 2 : N;

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/join3_sync.sv
// 3-to-1 join controller for 4-phase bundled-data handshakes entering a clocked domain.
// Optional stall watchdog enabled by defining JOIN3_SYNC_TIMEOUT_EN.
module join3_sync
  import join3_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_in1_i,
  input  logic             req_in2_i,
  input  logic             req_in3_i,
  input  logic             ack_out_i,
  output logic             req_out_o,
  output logic             ack_in1_o,
  output logic             ack_in2_o,
  output logic             ack_in3_o,
  output logic [CNT_W-1:0] hs_cnt_o,
  output logic             timeout_o
);

  logic r1, r2, r3, a;

  sync_ff #(.N(SYNC_STAGES)) u_sync_r1 (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(req_in1_i), .q_o(r1));
  sync_ff #(.N(SYNC_STAGES)) u_sync_r2 (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(req_in2_i), .q_o(r2));
  sync_ff #(.N(SYNC_STAGES)) u_sync_r3 (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(req_in3_i), .q_o(r3));
  sync_ff #(.N(SYNC_STAGES)) u_sync_a  (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(ack_out_i), .q_o(a));

  join3_state_e     state_q, state_d;
  logic             req_out_q, req_out_d;
  logic             ack_in_q, ack_in_d;
  logic [CNT_W-1:0] hs_cnt_q, hs_cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      req_out_q <= 1'b0;
      ack_in_q  <= 1'b0;
      hs_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_out_q <= req_out_d;
      ack_in_q  <= ack_in_d;
      hs_cnt_q  <= hs_cnt_d;
    end
  end

  // Outputs are decoded from the next state so they switch on the transition edge.
  always_comb begin
    state_d  = state_q;
    hs_cnt_d = hs_cnt_q;
    case (state_q)
      IDLE: if (r1 && r2 && r3) state_d = REQ;
      REQ:  if (a) state_d = ACK;
      ACK:  if (!r1 && !r2 && !r3) state_d = RTZ;
      RTZ: begin
        if (!a) begin
          state_d  = IDLE;
          hs_cnt_d = hs_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    req_out_d = (state_d == REQ) || (state_d == ACK);
    ack_in_d  = (state_d == ACK) || (state_d == RTZ);
  end

  assign req_out_o = req_out_q;
  assign ack_in1_o = ack_in_q;
  assign ack_in2_o = ack_in_q;
  assign ack_in3_o = ack_in_q;
  assign hs_cnt_o  = hs_cnt_q;

`ifdef JOIN3_SYNC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Counter saturates at the limit; the flag stays set until reset.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if ((state_q != IDLE) && (tmo_cnt_q != TMO_W'(TIMEOUT_CYCLES))) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
    timeout_d = timeout_q || (tmo_cnt_d == TMO_W'(TIMEOUT_CYCLES));
  end

  assign timeout_o = timeout_q;
`else
  // The limit only matters in the watchdog build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_join3_sync.sv
// Self-checking bench for join3_sync: directed handshakes then randomized input activity.
module tb_join3_sync;

  localparam int unsigned SYNC = 2;
  localparam int unsigned CW   = 2;
  localparam int unsigned TMO  = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_in1_i, req_in2_i, req_in3_i, ack_out_i;
  logic          req_out_o, ack_in1_o, ack_in2_o, ack_in3_o, timeout_o;
  logic [CW-1:0] hs_cnt_o;

  int checks   = 0;
  int failures = 0;

  join3_sync #(
    .SYNC_STAGES   (SYNC),
    .CNT_W         (CW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_in1_i(req_in1_i),
    .req_in2_i(req_in2_i),
    .req_in3_i(req_in3_i),
    .ack_out_i(ack_out_i),
    .req_out_o(req_out_o),
    .ack_in1_o(ack_in1_o),
    .ack_in2_o(ack_in2_o),
    .ack_in3_o(ack_in3_o),
    .hs_cnt_o (hs_cnt_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: inputs seen SYNC edges late, handshake phase 0..3
  // (waiting for all requests, requesting, acknowledged, returning to zero).
  logic [3:0]  pipe[$];
  logic [3:0]  seen;
  int          m_phase = 0;
  int          m_next;
  int unsigned m_cnt   = 0;
  int unsigned m_held  = 0;
  bit          m_tmo   = 1'b0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_phase = 0;
      m_cnt   = 0;
      m_held  = 0;
      m_tmo   = 1'b0;
      pipe    = {};
      repeat (SYNC) pipe.push_back(4'b0000);
    end else begin
      seen = pipe.pop_front();
      pipe.push_back({req_in1_i, req_in2_i, req_in3_i, ack_out_i});
      m_next = m_phase;
      if (m_phase == 0 && seen[3:1] == 3'b111) m_next = 1;
      else if (m_phase == 1 && seen[0]) m_next = 2;
      else if (m_phase == 2 && seen[3:1] == 3'b000) m_next = 3;
      else if (m_phase == 3 && !seen[0]) begin
        m_next = 0;
        m_cnt  = (m_cnt + 1) % (1 << CW);
      end
      if (m_next != m_phase) m_held = 0;
      else if (m_phase != 0) m_held++;
      if (m_held >= TMO) m_tmo = 1'b1;
      m_phase = m_next;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic exp_req, exp_ack, exp_tmo;
    exp_req = (m_phase == 1) || (m_phase == 2);
    exp_ack = (m_phase >= 2);
`ifdef JOIN3_SYNC_TIMEOUT_EN
    exp_tmo = m_tmo;
`else
    exp_tmo = 1'b0;
`endif
    chk("model_req_out", 32'(req_out_o), 32'(exp_req));
    chk("model_ack_in1", 32'(ack_in1_o), 32'(exp_ack));
    chk("model_ack_in2", 32'(ack_in2_o), 32'(exp_ack));
    chk("model_ack_in3", 32'(ack_in3_o), 32'(exp_ack));
    chk("model_hs_cnt", 32'(hs_cnt_o), m_cnt);
    chk("model_timeout", 32'(timeout_o), 32'(exp_tmo));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check_model();
    end
  endtask

  task automatic set_reqs(input logic v);
    req_in1_i = v;
    req_in2_i = v;
    req_in3_i = v;
  endtask

  task automatic handshake();
    set_reqs(1'b1);  cyc(3);
    ack_out_i = 1'b1; cyc(3);
    set_reqs(1'b0);  cyc(3);
    ack_out_i = 1'b0; cyc(3);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_out"}, 32'(req_out_o), 32'd0);
    chk({tag, "_ack_in1"}, 32'(ack_in1_o), 32'd0);
    chk({tag, "_ack_in2"}, 32'(ack_in2_o), 32'd0);
    chk({tag, "_ack_in3"}, 32'(ack_in3_o), 32'd0);
    chk({tag, "_hs_cnt"}, 32'(hs_cnt_o), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout_o), 32'd0);
  endtask

  int unsigned wrap_exp[5] = '{1, 2, 3, 0, 1};
  logic        exp_sticky;

  initial begin
`ifdef JOIN3_SYNC_TIMEOUT_EN
    exp_sticky = 1'b1;
`else
    exp_sticky = 1'b0;
`endif
    rst_ni = 1'b0;
    set_reqs(1'b0);
    ack_out_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset");
    rst_ni = 1'b1;
    cyc(2);

    // Single full handshake with latency checks
    set_reqs(1'b1);
    cyc(2); chk("t1_req_before_lat", 32'(req_out_o), 32'd0);
    cyc(1); chk("t1_req_after_lat", 32'(req_out_o), 32'd1);
    ack_out_i = 1'b1;
    cyc(2); chk("t1_ack_before_lat", 32'(ack_in1_o), 32'd0);
    cyc(1);
    chk("t1_ack_in1", 32'(ack_in1_o), 32'd1);
    chk("t1_ack_in2", 32'(ack_in2_o), 32'd1);
    chk("t1_ack_in3", 32'(ack_in3_o), 32'd1);
    set_reqs(1'b0);
    cyc(3); chk("t1_req_drop", 32'(req_out_o), 32'd0);
    chk("t1_ack_hold_rtz", 32'(ack_in2_o), 32'd1);
    ack_out_i = 1'b0;
    cyc(3);
    chk("t1_ack_release", 32'(ack_in3_o), 32'd0);
    chk("t1_hs_cnt", 32'(hs_cnt_o), 32'd1);

    // Staggered arrival: last request at t=25 gives req_out at t=28
    req_in1_i = 1'b1; cyc(10);
    req_in3_i = 1'b1; cyc(15);
    req_in2_i = 1'b1;
    cyc(2); chk("t2_req_t27", 32'(req_out_o), 32'd0);
    cyc(1); chk("t2_req_t28", 32'(req_out_o), 32'd1);
    ack_out_i = 1'b1; cyc(3);
    set_reqs(1'b0);   cyc(3);
    ack_out_i = 1'b0; cyc(3);
    chk("t2_hs_cnt", 32'(hs_cnt_o), 32'd2);

    // Early acknowledge: REQ then ACK on consecutive edges
    ack_out_i = 1'b1; cyc(4);
    set_reqs(1'b1);
    cyc(3);
    chk("t3_req_first", 32'(req_out_o), 32'd1);
    chk("t3_ack_not_yet", 32'(ack_in1_o), 32'd0);
    cyc(1);
    chk("t3_ack_next", 32'(ack_in1_o), 32'd1);
    chk("t3_req_still", 32'(req_out_o), 32'd1);
    set_reqs(1'b0);   cyc(3);
    ack_out_i = 1'b0; cyc(3);
    chk("t3_hs_cnt", 32'(hs_cnt_o), 32'd3);

    // Stall in REQ long enough to trip the watchdog (if built in)
    set_reqs(1'b1);
    cyc(3); chk("t6_in_req", 32'(req_out_o), 32'd1);
    chk("t6_no_tmo_yet", 32'(timeout_o), 32'd0);
    cyc(7); chk("t6_tmo_7th", 32'(timeout_o), 32'd0);
    cyc(1); chk("t6_tmo_8th", 32'(timeout_o), 32'(exp_sticky));
    cyc(4);
    ack_out_i = 1'b1; cyc(3);
    set_reqs(1'b0);   cyc(3);
    ack_out_i = 1'b0; cyc(3);
    chk("t6_tmo_sticky", 32'(timeout_o), 32'(exp_sticky));
    chk("t6_hs_cnt_wrap", 32'(hs_cnt_o), 32'd0);

    // Asynchronous reset while in ACK
    set_reqs(1'b1);   cyc(3);
    ack_out_i = 1'b1; cyc(3);
    chk("t5_in_ack", 32'(ack_in1_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1 chk_all_zero("t5_async");
    ack_out_i = 1'b0;
    @(negedge clk_i);
    chk_all_zero("t5_held");
    rst_ni = 1'b1;
    cyc(2); chk("t5_req_before_lat", 32'(req_out_o), 32'd0);
    cyc(1); chk("t5_req_after_lat", 32'(req_out_o), 32'd1);
    ack_out_i = 1'b1; cyc(3);
    set_reqs(1'b0);   cyc(3);
    ack_out_i = 1'b0; cyc(3);
    chk("t5_hs_cnt", 32'(hs_cnt_o), 32'd1);

    // Counter wrap from a fresh reset
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(2);
    for (int k = 0; k < 5; k++) begin
      handshake();
      chk("t4_wrap_seq", 32'(hs_cnt_o), wrap_exp[k]);
    end

    // Randomized input activity with occasional mid-cycle resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req_in1_i = 1'($urandom);
      if ($urandom_range(0, 3) == 0) req_in2_i = 1'($urandom);
      if ($urandom_range(0, 3) == 0) req_in3_i = 1'($urandom);
      if ($urandom_range(0, 3) == 0) ack_out_i = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_ni = 1'b0;
        #1 chk_all_zero("rand_async");
        @(negedge clk_i);
        rst_ni = 1'b1;
      end else begin
        cyc(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
